simple_dma: RTL and testbench



---
 rtl/simple_dma.sv | 184 ++++++++++++++++++
 tb/tb_simple_dma.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_dma.sv
`timescale 1ns/1ps
// simple_dma: single-channel word-granular memory-to-memory copy engine.
//
// A start pulse in IDLE latches src_addr, dst_addr and xfer_size. The
// engine then copies xfer_size 32-bit words, one at a time: read one word
// from the source pointer, then write it to the destination pointer. All
// accesses go through one shared req/ack memory port.
//
// Handshake: mem_req is raised only when both mem_req and mem_ack are low,
// so a stale ack from the previous access is never mistaken for a new one.
// While mem_req is high, mem_addr and mem_we are held stable. An access
// completes at the rising edge where mem_req and mem_ack are both high; at
// that edge mem_req drops. The memory may hold off mem_ack indefinitely.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      begin transfer (sampled only in IDLE)
//   src_addr   source byte address, latched at start
//   dst_addr   destination byte address, latched at start
//   xfer_size  number of 32-bit words to copy, latched at start
//   busy       high while a transfer is in progress
//   done       one-cycle completion pulse
//   mem_addr   address of the current access (holds last value when idle)
//   mem_wdata  write data (last word read)
//   mem_we     1 = write, 0 = read; valid while mem_req is high
//   mem_rdata  read data, valid when mem_ack is high
//   mem_req    access request
//   mem_ack    access acknowledge
//   dbg_state  current FSM state (0 IDLE, 1 READ, 2 WRITE, 3 DONE)
module simple_dma #(
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [31:0] xfer_size,
  output logic        busy,
  output logic        done,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] src_ptr_q, src_ptr_d;
  logic [31:0] dst_ptr_q, dst_ptr_d;
  logic [31:0] remaining_q, remaining_d;
  logic [31:0] data_q, data_d;
  logic [31:0] addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        req_q, req_d;
  logic        we_q, we_d;

  // Request may be issued only when the port is fully idle (no stale ack).
  logic can_issue;
  logic complete;

  assign can_issue = !req_q && !mem_ack;
  assign complete  = req_q && mem_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      src_ptr_q   <= 32'h0;
      dst_ptr_q   <= 32'h0;
      remaining_q <= 32'h0;
      data_q      <= 32'h0;
      addr_q      <= 32'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      req_q       <= req_d;
      we_q        <= we_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    addr_d      = addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    req_d       = req_q;
    we_d        = we_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_ptr_d   = src_addr;
          dst_ptr_d   = dst_addr;
          remaining_d = xfer_size;
          if (xfer_size == 32'h0) begin
            // Empty transfer: straight to the completion pulse, no access.
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_READ;
            busy_d  = 1'b1;
          end
        end
      end

      S_READ: begin
        if (can_issue) begin
          req_d  = 1'b1;
          addr_d = src_ptr_q;
          we_d   = 1'b0;
        end else if (complete) begin
          req_d     = 1'b0;
          data_d    = mem_rdata;
          src_ptr_d = src_ptr_q + ADDR_STEP;
          state_d   = S_WRITE;
        end
      end

      S_WRITE: begin
        if (can_issue) begin
          req_d  = 1'b1;
          addr_d = dst_ptr_q;
          we_d   = 1'b1;
        end else if (complete) begin
          req_d       = 1'b0;
          we_d        = 1'b0;
          dst_ptr_d   = dst_ptr_q + ADDR_STEP;
          remaining_d = remaining_q - 32'd1;
          // remaining_q == 1 means this write was the last word.
          if (remaining_q == 32'd1) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_READ;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = data_q;
  assign mem_we    = we_q;
  assign mem_req   = req_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_simple_dma.sv
`timescale 1ns/1ps
module tb_simple_dma;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [31:0] xfer_size;
  logic        busy;
  logic        done;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic        mem_ack;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  simple_dma dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .xfer_size (xfer_size),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .dbg_state (dbg_state)
  );

  // ---------------- memory model ----------------
  // fast: ack <= req; rdata increments on every clocked read request.
  // slow: ack rises after 5 cycles of request; each read returns the next
  //       value of A5A5A5A6, A8, AA, ... so both modes yield the same data.
  logic        slow_mode = 1'b0;
  logic [31:0] slow_cnt;
  logic [31:0] slow_rd_n;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_ack   <= 1'b0;
      mem_rdata <= 32'hA5A5A5A5;
      slow_cnt  <= 32'h0;
      slow_rd_n <= 32'h0;
    end else if (!slow_mode) begin
      mem_ack <= mem_req;
      if (mem_req && !mem_we) mem_rdata <= mem_rdata + 32'd1;
    end else begin
      if (mem_req && !mem_ack) begin
        if (slow_cnt == 32'd4) begin
          mem_ack <= 1'b1;
          if (!mem_we) begin
            mem_rdata <= 32'hA5A5A5A6 + (slow_rd_n << 1);
            slow_rd_n <= slow_rd_n + 32'd1;
          end
        end
        slow_cnt <= slow_cnt + 32'd1;
      end else if (!mem_req) begin
        mem_ack  <= 1'b0;
        slow_cnt <= 32'h0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [64:0] obs_mem [0:255];
  int          obs_n     = 0;
  int          done_cnt  = 0;
  int          write_cnt = 0;
  int          req_cnt   = 0;
  int          busy_cnt  = 0;
  int          viol_cnt  = 0;
  logic        prev_req  = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic        prev_we   = 1'b0;

  always @(negedge clk) begin
    if (mem_req && mem_ack) begin
      if (obs_n < 256) obs_mem[obs_n] = {mem_we, mem_addr, (mem_we ? mem_wdata : 32'h0)};
      obs_n++;
      if (mem_we) write_cnt++;
    end
    if (done)    done_cnt++;
    if (mem_req) req_cnt++;
    if (busy)    busy_cnt++;
    if (prev_req && mem_req && ((mem_addr != prev_addr) || (mem_we != prev_we))) viol_cnt++;
    prev_req  = mem_req;
    prev_addr = mem_addr;
    prev_we   = mem_we;
  end

  // ---------------- scoreboard ----------------
  logic [64:0] exp_q[$];
  int          n_pass  = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_expected(input logic [31:0] src, input logic [31:0] dst, input int words);
    for (int i = 0; i < words; i++) begin
      logic [31:0] k;
      k = 32'(i);
      exp_q.push_back({1'b0, src + (k << 2), 32'h0});
      exp_q.push_back({1'b1, dst + (k << 2), 32'hA5A5A5A6 + (k << 1)});
    end
  endtask

  task automatic compare_accesses(input string tag, input int b_obs);
    int n;
    n = obs_n - b_obs;
    check({tag, "_access_count"}, 96'(n), 96'(exp_q.size()));
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      logic [64:0] e;
      e = exp_q.pop_front();
      check($sformatf("%s_access%0d", tag, i), 96'(obs_mem[b_obs + i]), 96'(e));
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    start     = 1'b0;
    src_addr  = 32'h0;
    dst_addr  = 32'h0;
    xfer_size = 32'h0;
    reset_n   = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] size;
    bit          slow;
    bit          start_mid;
    logic [1:0]  exp_resp;    // {busy, done} one cycle after start
    int          exp_writes;
  } vec_t;

  task automatic run_vec(input int idx, input vec_t v, input bit skip_reset);
    int b_obs, b_done, b_wr, b_req, b_busy, b_viol, cyc;
    string tag;
    tag = $sformatf("v%0d", idx);
    slow_mode = v.slow;
    if (!skip_reset) begin
      do_reset();
      check({tag, "_reset_outputs"},
            96'({busy, done, mem_req, mem_we, mem_addr, mem_wdata, dbg_state}), 96'h0);
      reset_n = 1'b1;
      @(negedge clk);
    end
    b_obs = obs_n; b_done = done_cnt; b_wr = write_cnt;
    b_req = req_cnt; b_busy = busy_cnt; b_viol = viol_cnt;
    push_expected(v.src, v.dst, v.exp_writes);

    src_addr  = v.src;
    dst_addr  = v.dst;
    xfer_size = v.size;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_start_resp"}, 96'({busy, done}), 96'(v.exp_resp));

    if (v.start_mid) begin
      cyc = 0;
      while ((write_cnt - b_wr) < 2 && cyc < 3000) begin
        @(posedge clk);
        cyc++;
      end
      @(negedge clk);
      src_addr  = 32'h5000;
      dst_addr  = 32'h6000;
      xfer_size = 32'd3;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end

    cyc = 0;
    while ((done_cnt - b_done) < 1 && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    repeat (12) @(negedge clk);

    check({tag, "_done_count"}, 96'(done_cnt - b_done), 96'd1);
    check({tag, "_write_count"}, 96'(write_cnt - b_wr), 96'(v.exp_writes));
    check({tag, "_busy_final"}, 96'(busy), 96'd0);
    check({tag, "_held_stable"}, 96'(viol_cnt - b_viol), 96'd0);
    if (v.size == 32'h0) begin
      check({tag, "_no_req"}, 96'(req_cnt - b_req), 96'd0);
      check({tag, "_no_busy"}, 96'(busy_cnt - b_busy), 96'd0);
    end
    compare_accesses(tag, b_obs);
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t vecs[5];
    vec_t post;
    int   b_obs, b_done, b_wr, cyc;

    // basic copy
    vecs[0] = '{src: 32'h1000, dst: 32'h2000, size: 32'd8, slow: 1'b0, start_mid: 1'b0,
                exp_resp: 2'b10, exp_writes: 8};
    // size 0
    vecs[1] = '{src: 32'h1000, dst: 32'h2000, size: 32'd0, slow: 1'b0, start_mid: 1'b0,
                exp_resp: 2'b01, exp_writes: 0};
    // start while busy is ignored
    vecs[2] = '{src: 32'h1000, dst: 32'h2000, size: 32'd8, slow: 1'b0, start_mid: 1'b1,
                exp_resp: 2'b10, exp_writes: 8};
    // slow memory
    vecs[3] = '{src: 32'h1000, dst: 32'h2000, size: 32'd8, slow: 1'b1, start_mid: 1'b0,
                exp_resp: 2'b10, exp_writes: 8};
    // source pointer wraps
    vecs[4] = '{src: 32'hFFFFFFFC, dst: 32'h2000, size: 32'd2, slow: 1'b0, start_mid: 1'b0,
                exp_resp: 2'b10, exp_writes: 2};

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i], 1'b0);

    // Reset mid-transfer after the 3rd write, then a fresh size-2 copy.
    slow_mode = 1'b0;
    do_reset();
    reset_n = 1'b1;
    @(negedge clk);
    b_obs = obs_n; b_done = done_cnt; b_wr = write_cnt;
    push_expected(32'h3000, 32'h4000, 3);
    src_addr  = 32'h3000;
    dst_addr  = 32'h4000;
    xfer_size = 32'd8;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while ((write_cnt - b_wr) < 3 && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_outputs",
          96'({busy, done, mem_req, mem_we, mem_addr, mem_wdata, dbg_state}), 96'h0);
    repeat (4) @(negedge clk);
    check("rst_mid_no_done", 96'(done_cnt - b_done), 96'd0);
    check("rst_mid_writes", 96'(write_cnt - b_wr), 96'd3);
    compare_accesses("rst_mid", b_obs);
    reset_n = 1'b1;
    @(negedge clk);
    post = '{src: 32'h3000, dst: 32'h4000, size: 32'd2, slow: 1'b0, start_mid: 1'b0,
             exp_resp: 2'b10, exp_writes: 2};
    run_vec(5, post, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
